// File: rtl/cmd_issuer_if.sv
// Bundle of the fetch, executor and status signals of the command issuer.
// The master modport is the issuer; the slave modport is its environment.
interface cmd_issuer_if #(
    parameter int ADDR_W = 32
);
    logic              START_;
    logic [ADDR_W-1:0] START_ADDR_;
    logic              MEM_REQ_;
    logic [ADDR_W-1:0] MEM_ADDR_;
    logic [31:0]       MEM_DATA_;
    logic              MEM_VALID_;
    logic              EXEC_FL_;
    logic [5:0]        CMD_FL_;
    logic [95:0]       CMD_ARG_;
    logic              READY_FL_;
    logic              JMP_FL_;
    logic [31:0]       NEW_EXEC_ADDR_OFF_;
    logic [ADDR_W-1:0] CUR_PC_;
    logic              BUSY_;
    logic              HALTED_;
    logic              ERR_FL_;

    modport master (
        input  START_, START_ADDR_, MEM_DATA_, MEM_VALID_,
               READY_FL_, JMP_FL_, NEW_EXEC_ADDR_OFF_,
        output MEM_REQ_, MEM_ADDR_, EXEC_FL_, CMD_FL_, CMD_ARG_,
               CUR_PC_, BUSY_, HALTED_, ERR_FL_
    );

    modport slave (
        output START_, START_ADDR_, MEM_DATA_, MEM_VALID_,
               READY_FL_, JMP_FL_, NEW_EXEC_ADDR_OFF_,
        input  MEM_REQ_, MEM_ADDR_, EXEC_FL_, CMD_FL_, CMD_ARG_,
               CUR_PC_, BUSY_, HALTED_, ERR_FL_
    );
endinterface

// File: rtl/cmd_issuer.sv
// Fetch-and-issue sequencer: reads header + 0..3 argument words, strobes the
// executor, then advances the PC sequentially or by the returned jump offset.
module cmd_issuer #(
    parameter int ADDR_W = 32
) (
    input  logic         CLK_,
    input  logic         RST_,
    cmd_issuer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HDR, S_FETCH_ARG, S_ISSUE, S_WAIT, S_HALT, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [5:0]        fl_q, fl_d;
    logic [95:0]       arg_q, arg_d;
    logic [1:0]        n_q, n_d;
    logic [1:0]        k_q, k_d;

    logic [5:0]        hdr_fl;
    logic [1:0]        hdr_n;
    logic              hdr_onehot;
    logic [ADDR_W-1:0] jmp_sum;
    logic              unused_bits;

    assign hdr_fl      = bus.MEM_DATA_[31:26];
    assign hdr_n       = bus.MEM_DATA_[25:24];
    assign hdr_onehot  = (hdr_fl & (hdr_fl - 6'd1)) == 6'd0;
    assign jmp_sum     = pc_q + ADDR_W'($signed(bus.NEW_EXEC_ADDR_OFF_));
    assign unused_bits = ^{bus.MEM_DATA_[23:0], bus.START_ADDR_[1:0], jmp_sum[1:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        fl_d    = fl_q;
        arg_d   = arg_q;
        n_d     = n_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (bus.START_) begin
                    pc_d    = {bus.START_ADDR_[ADDR_W-1:2], 2'b00};
                    req_d   = 1'b0;
                    state_d = S_FETCH_HDR;
                end
            end
            S_FETCH_HDR: begin
                // Request goes up one cycle after entry and drops right after each accept.
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end else if (bus.MEM_VALID_) begin
                    req_d = 1'b0;
                    if (hdr_fl == 6'd0) begin
                        state_d = S_HALT;
                    end else if (!hdr_onehot) begin
                        state_d = S_ERR;
                    end else begin
                        fl_d    = hdr_fl;
                        n_d     = hdr_n;
                        k_d     = 2'd0;
                        arg_d   = '0;
                        state_d = (hdr_n != 2'd0) ? S_FETCH_ARG : S_ISSUE;
                    end
                end
            end
            S_FETCH_ARG: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q + ADDR_W'({k_q, 2'b00}) + ADDR_W'(4);
                end else if (bus.MEM_VALID_) begin
                    req_d                    = 1'b0;
                    arg_d[{k_q, 5'd0} +: 32] = bus.MEM_DATA_;
                    k_d                      = k_q + 2'd1;
                    if (k_q == n_q - 2'd1) state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.READY_FL_) begin
                    if (bus.JMP_FL_) pc_d = {jmp_sum[ADDR_W-1:2], 2'b00};
                    else             pc_d = pc_q + ADDR_W'({n_q, 2'b00}) + ADDR_W'(4);
                    state_d = S_FETCH_HDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_ or posedge RST_) begin
        if (RST_) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            fl_q    <= '0;
            arg_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            fl_q    <= fl_d;
            arg_q   <= arg_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    assign bus.MEM_REQ_  = req_q;
    assign bus.MEM_ADDR_ = addr_q;
    assign bus.EXEC_FL_  = (state_q == S_ISSUE);
    assign bus.CMD_FL_   = fl_q;
    assign bus.CMD_ARG_  = arg_q;
    assign bus.CUR_PC_   = pc_q;
    assign bus.BUSY_     = (state_q == S_FETCH_HDR) || (state_q == S_FETCH_ARG) ||
                           (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.HALTED_   = (state_q == S_HALT);
    assign bus.ERR_FL_   = (state_q == S_ERR);
endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: memory and executor responders, a directed vector
// table, reset/ignored-START sequence, and random programs vs a program walker.
module tb_cmd_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_issuer_if #(.ADDR_W(32)) bus ();
    cmd_issuer #(.ADDR_W(32)) dut (.CLK_(clk), .RST_(rst), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  fl;
        logic [95:0] arg;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [31:0] start;
        logic [31:0] hdr;
        logic [31:0] a0, a1, a2;
        int          stall;
        int          dly;
        logic        jmp;
        logic [31:0] off;
        int          exp_end;   // 0 halted, 1 error
        int          exp_iss;
        logic [31:0] exp_first;
        logic [5:0]  exp_fl;
        logic [95:0] exp_arg;
        logic [31:0] exp_next;
    } vec_t;

    logic [31:0] mem [logic [31:0]];
    logic        plan_jmp [256];
    logic [31:0] plan_off [256];
    int  mem_stall = 0, exe_delay = 1, cap_abs = 1 << 30;
    bit  mem_rand = 0, exe_rand = 0, early_rdy = 0;
    int  n_chk = 0, n_fail = 0, cyc = 0, issue_n = 0, stab_err = 0;
    iss_t        iss_q[$];
    iss_t        exp_q[$];
    logic [31:0] fetch_q[$];
    int          fcyc_q[$];
    int   tgt = 0, scnt = 0, wcnt = 0, cur_idx = 0;
    logic prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory and executor responders, plus fetch/issue monitors.
    always @(negedge clk) begin
        iss_t r;
        if (bus.MEM_REQ_ && !prev_req) begin
            fetch_q.push_back(bus.MEM_ADDR_);
            fcyc_q.push_back(cyc);
            tgt  = mem_rand ? $urandom_range(0, 3) : mem_stall;
            scnt = 0;
        end
        if (bus.MEM_REQ_ && prev_req && bus.MEM_ADDR_ !== prev_addr) stab_err++;
        prev_req  = bus.MEM_REQ_;
        prev_addr = bus.MEM_ADDR_;
        if (bus.MEM_REQ_ && scnt >= tgt) begin
            bus.MEM_VALID_ = 1'b1;
            bus.MEM_DATA_  = rd(bus.MEM_ADDR_);
        end else begin
            if (bus.MEM_REQ_) scnt++;
            bus.MEM_VALID_ = 1'b0;
            bus.MEM_DATA_  = $urandom;
        end
        bus.JMP_FL_            = 1'($urandom);
        bus.NEW_EXEC_ADDR_OFF_ = $urandom;
        if (bus.EXEC_FL_) begin
            r.pc = bus.CUR_PC_; r.fl = bus.CMD_FL_; r.arg = bus.CMD_ARG_; r.cyc = cyc;
            iss_q.push_back(r);
            cur_idx = issue_n;
            issue_n++;
            wcnt = (cur_idx < cap_abs) ? (exe_rand ? $urandom_range(1, 4) : exe_delay) : 0;
            bus.READY_FL_ = early_rdy;
        end else if (wcnt > 0) begin
            wcnt--;
            bus.READY_FL_ = (wcnt == 0);
            if (wcnt == 0) begin
                bus.JMP_FL_            = plan_jmp[cur_idx % 256];
                bus.NEW_EXEC_ADDR_OFF_ = plan_off[cur_idx % 256];
            end
        end else begin
            bus.READY_FL_ = 1'b0;
        end
    end

    task automatic start_at(input logic [31:0] a);
        @(posedge clk); #2;
        bus.START_ = 1'b1; bus.START_ADDR_ = a;
        @(posedge clk); #2;
        bus.START_ = 1'b0; bus.START_ADDR_ = $urandom;
    endtask

    // kind: 0 halted, 1 error, 2 parked after stop issues, 3 timed out
    task automatic wait_end(input int stop, output int kind);
        kind = 3;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #2;
            if (bus.HALTED_) begin kind = 0; break; end
            if (bus.ERR_FL_) begin kind = 1; break; end
            if (issue_n >= stop) begin
                repeat (8) @(posedge clk);
                #2;
                kind = 2;
                break;
            end
        end
    endtask

    // Reference: walk the program image by the command rules.
    task automatic walk(input logic [31:0] st, input int ib, input int lim, output int kind);
        logic [31:0] pc, h;
        iss_t e;
        int n;
        pc = st & ~32'h3;
        exp_q.delete();
        forever begin
            h = rd(pc);
            if (h[31:26] == 6'd0) begin kind = 0; return; end
            if ($countones(h[31:26]) != 1) begin kind = 1; return; end
            n = int'(h[25:24]);
            e.pc = pc; e.fl = h[31:26]; e.arg = '0; e.cyc = 0;
            for (int k = 0; k < n; k++) e.arg[32*k +: 32] = rd(pc + 32'(4 * (k + 1)));
            exp_q.push_back(e);
            if (exp_q.size() == lim) begin kind = 2; return; end
            if (plan_jmp[(ib + exp_q.size() - 1) % 256]) pc = (pc + plan_off[(ib + exp_q.size() - 1) % 256]) & ~32'h3;
            else pc = pc + 32'(4 * (n + 1));
        end
    endtask

    vec_t tbl[8];

    initial begin
        int kind, ib, fb;
        logic [159:0] act;
        bus.START_ = 1'b0;
        bus.START_ADDR_ = '0;
        tbl[0] = '{32'h100, 32'h80000000, 0, 0, 0, 0, 3, 0, 0, 0, 1, 32'h100, 6'b100000, 96'h0, 32'h104};
        tbl[1] = '{32'h0, 32'h83000000, 32'h00200189, 32'hFFF, 32'hFFF, 0, 1, 0, 0, 0, 1, 32'h0, 6'b100000,
                   96'h00000FFF_00000FFF_00200189, 32'h10};
        tbl[2] = '{32'h40, 32'h04000000, 0, 0, 0, 0, 2, 1, 32'hFFFFFFF0, 0, 1, 32'h40, 6'b000001, 96'h0, 32'h30};
        tbl[3] = '{32'hFFFFFFFC, 32'h08000000, 0, 0, 0, 0, 1, 1, 32'h7, 0, 1, 32'hFFFFFFFC, 6'b000010, 96'h0, 32'h0};
        tbl[4] = '{32'h20, 32'h0C000000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h20, 6'b000010, 96'h0, 32'h0};
        tbl[5] = '{32'h203, 32'h00000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h200, 6'b000010, 96'h0, 32'h0};
        tbl[6] = '{32'h300, 32'h41000000, 32'hDEADBEEF, 0, 0, 5, 2, 0, 0, 0, 1, 32'h300, 6'b010000,
                   96'h00000000_00000000_DEADBEEF, 32'h308};
        tbl[7] = '{32'h1000, 32'h12000000, 32'h11111111, 32'h22222222, 0, 1, 4, 1, 32'h23, 0, 1, 32'h1000,
                   6'b000100, 96'h00000000_22222222_11111111, 32'h1020};

        repeat (2) @(posedge clk);
        #2;
        chk("rst_outputs", {bus.MEM_REQ_, bus.MEM_ADDR_, bus.EXEC_FL_, bus.CMD_FL_, bus.CUR_PC_,
                            bus.BUSY_, bus.HALTED_, bus.ERR_FL_}, '0);
        chk("rst_arg", bus.CMD_ARG_, '0);
        rst = 1'b0;

        early_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem.delete();
            mem[tbl[i].start & ~32'h3]           = tbl[i].hdr;
            mem[(tbl[i].start & ~32'h3) + 32'h4] = tbl[i].a0;
            mem[(tbl[i].start & ~32'h3) + 32'h8] = tbl[i].a1;
            mem[(tbl[i].start & ~32'h3) + 32'hC] = tbl[i].a2;
            mem_stall = tbl[i].stall;
            exe_delay = tbl[i].dly;
            ib = issue_n;
            fb = fetch_q.size();
            plan_jmp[ib % 256] = tbl[i].jmp;
            plan_off[ib % 256] = tbl[i].off;
            start_at(tbl[i].start);
            wait_end(1 << 30, kind);
            chk($sformatf("v%0d_end", i), kind, tbl[i].exp_end);
            chk($sformatf("v%0d_issues", i), issue_n - ib, tbl[i].exp_iss);
            act = (fetch_q.size() > fb) ? fetch_q[fb] : 'x;
            chk($sformatf("v%0d_first_fetch", i), act, tbl[i].exp_first);
            chk($sformatf("v%0d_req_low", i), bus.MEM_REQ_, 1'b0);
            chk($sformatf("v%0d_cmd_fl", i), bus.CMD_FL_, tbl[i].exp_fl);
            chk($sformatf("v%0d_cmd_arg", i), bus.CMD_ARG_, tbl[i].exp_arg);
            if (tbl[i].exp_iss == 1 && iss_q.size() > ib) begin
                chk($sformatf("v%0d_issue", i), {iss_q[ib].pc, iss_q[ib].fl, iss_q[ib].arg},
                    {tbl[i].start & ~32'h3, tbl[i].exp_fl, tbl[i].exp_arg});
                chk($sformatf("v%0d_next_fetch", i), fetch_q[$], tbl[i].exp_next);
                chk($sformatf("v%0d_ready_lat", i), fcyc_q[$] - iss_q[ib].cyc, tbl[i].dly + 2);
            end
        end
        chk("addr_stable", stab_err, 0);

        // Reset while waiting on the executor; late READY must be ignored.
        early_rdy = 1'b0;
        mem.delete();
        mem[32'h500] = 32'h80000000;
        exe_delay = 12;
        ib = issue_n;
        plan_jmp[ib % 256] = 1'b0;
        plan_off[ib % 256] = '0;
        start_at(32'h500);
        for (int t = 0; t < 50 && issue_n == ib; t++) begin @(posedge clk); #2; end
        chk("wait_issued", issue_n - ib, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("wait_busy", bus.BUSY_, 1'b1);
        bus.START_ = 1'b1; bus.START_ADDR_ = 32'h900;
        @(posedge clk); #2;
        bus.START_ = 1'b0;
        chk("start_ignored_pc", bus.CUR_PC_, 32'h500);
        chk("start_ignored_busy", bus.BUSY_, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {bus.MEM_REQ_, bus.MEM_ADDR_, bus.EXEC_FL_, bus.CMD_FL_, bus.CUR_PC_,
                                  bus.BUSY_, bus.HALTED_, bus.ERR_FL_}, '0);
        chk("async_rst_arg", bus.CMD_ARG_, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        fb = fetch_q.size();
        repeat (14) @(posedge clk);
        #2;
        chk("late_ready_idle", {bus.BUSY_, bus.MEM_REQ_, bus.CUR_PC_}, '0);
        chk("late_ready_nofetch", fetch_q.size() - fb, 0);

        // Random programs against the walker.
        mem_rand = 1'b1;
        exe_rand = 1'b1;
        for (int p = 0; p < 6; p++) begin
            logic [31:0] st, a;
            logic [5:0]  fl;
            logic [1:0]  n;
            int ek;
            mem.delete();
            st = (p == 5) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 3))) : ($urandom & 32'h0000FFFF);
            a = st & ~32'h3;
            for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
                fl = 6'(1 << $urandom_range(0, 5));
                n  = 2'($urandom_range(0, 3));
                mem[a] = {fl, n, 24'($urandom)};
                for (int k = 0; k < int'(n); k++) mem[a + 32'(4 * (k + 1))] = $urandom;
                a = a + 32'(4 * (int'(n) + 1));
            end
            case ($urandom_range(0, 2))
                0: mem[a] = 32'h0;
                1: mem[a] = {6'b101000, 26'($urandom)};
                default: ;
            endcase
            ib = issue_n;
            for (int j = 0; j < 17; j++) begin
                plan_jmp[(ib + j) % 256] = ($urandom_range(0, 3) == 0);
                plan_off[(ib + j) % 256] = 32'($urandom_range(0, 96)) - 32'd48;
            end
            cap_abs   = ib + 16;
            early_rdy = 1'($urandom);
            walk(st, ib, 17, ek);
            start_at(st);
            wait_end(ib + 17, kind);
            chk($sformatf("r%0d_end", p), kind, ek);
            chk($sformatf("r%0d_count", p), issue_n - ib, exp_q.size());
            for (int j = 0; j < exp_q.size(); j++) begin
                act = (iss_q.size() > ib + j) ? {iss_q[ib + j].pc, iss_q[ib + j].fl, iss_q[ib + j].arg} : 'x;
                chk($sformatf("r%0d_issue%0d", p, j), act, {exp_q[j].pc, exp_q[j].fl, exp_q[j].arg});
            end
            @(posedge clk); #2;
            rst = 1'b1;
            @(posedge clk); #2;
            rst = 1'b0;
        end
        chk("rnd_addr_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Fetch-and-issue sequencer that feeds the command executor. Reads variable-length commands (one header word plus 0–3 argument words) from instruction memory through a request/valid handshake, and packs them into the executor's 6-bit flag / 96-bit argument bus. Strobes the executor and waits for its ready flag, then advances the program counter sequentially or by the executor's jump offset. Sits between instruction memory and the executor as the command source.

## Interface
Parameters:
- ADDR_W, 32, byte-address and program-counter width.
- Fixed: word 32 bits; CMD_FL_ 6 bits; CMD_ARG_ 96 bits.

Ports:
- CLK_  in  1  clock; everything on the rising edge.
- RST_  in  1  reset, asynchronous, active-high.
- START_  in  1  one-cycle start pulse; honoured only in IDLE, HALT or ERR.
- START_ADDR_  in  32  first header address; sampled with START_.
- MEM_REQ_  out  1  fetch request.
- MEM_ADDR_  out  32  fetch byte address; stable while MEM_REQ_ high.
- MEM_DATA_  in  32  fetched word.
- MEM_VALID_  in  1  MEM_DATA_ valid for the current request.
- EXEC_FL_  out  1  one-cycle issue strobe to the executor.
- CMD_FL_  out  6  command flags; one-hot, held from issue until ready.
- CMD_ARG_  out  96  arg0 [31:0], arg1 [63:32], arg2 [95:64]; unused slots zero.
- READY_FL_  in  1  executor finished the issued command.
- JMP_FL_  in  1  take jump; sampled with READY_FL_.
- NEW_EXEC_ADDR_OFF_  in  32  signed byte offset; sampled with READY_FL_.
- CUR_PC_  out  32  address of the current command header.
- BUSY_  out  1  high in FETCH_HDR, FETCH_ARG, ISSUE, WAIT.
- HALTED_  out  1  high in HALT.
- ERR_FL_  out  1  high in ERR.

## Operation
- Header word: [31:26] command flags, [25:24] argument count N (0–3), [23:0] ignored.
- States: IDLE, FETCH_HDR, FETCH_ARG, ISSUE, WAIT, HALT, ERR.
- IDLE: on START_, PC <= START_ADDR_ with bits [1:0] forced to 0, then go to FETCH_HDR.
- FETCH_HDR: request PC. On accept:
  - flags == 0 -> HALT.
  - flags not one-hot -> ERR.
  - otherwise latch flags and N; clear CMD_ARG_. Go to FETCH_ARG if N > 0, else ISSUE.
- FETCH_ARG: request PC+4·(k+1) for k = 0..N−1. Accepted word goes to slot k. After slot N−1, go to ISSUE.
- ISSUE: EXEC_FL_ = 1 for exactly one cycle, then WAIT.
- WAIT: on READY_FL_:
  - if JMP_FL_, PC <= PC + NEW_EXEC_ADDR_OFF_ with bits [1:0] forced to 0;
  - else PC <= PC + 4·(1+N);
  - then FETCH_HDR.
- Address arithmetic is 32-bit, wraps modulo 2^32, and is computed relative to the header address.
- HALT / ERR: idle with MEM_REQ_ = 0; START_ restarts as from IDLE.
- START_ in any other state is ignored.
- CMD_FL_ and CMD_ARG_ keep their last values until the next header is accepted.

## Timing
- Reset values: MEM_REQ_ 0, MEM_ADDR_ 0, EXEC_FL_ 0, CMD_FL_ 0, CMD_ARG_ 0, CUR_PC_ 0, BUSY_ 0, HALTED_ 0, ERR_FL_ 0; state IDLE.
- Reset asserted mid-operation returns to IDLE immediately. Any outstanding fetch or executor handshake is abandoned.
- A word is accepted on an edge where MEM_REQ_ & MEM_VALID_ are both high. MEM_VALID_ is ignored while MEM_REQ_ = 0.
- MEM_REQ_ rises the cycle after entering a fetch state. After an accept it deasserts for one cycle before the next request.
- With zero-wait memory, a command with N arguments takes 2(1+N) cycles to issue, plus 1 ISSUE cycle, plus 1 or more WAIT cycles.
- READY_FL_ is ignored in the EXEC_FL_ cycle; it is sampled from the following cycle on. The earliest completion is therefore the cycle after the strobe.
- CUR_PC_ updates on the same edge as leaving WAIT.

## Test plan
- Header 0x80000000 (flags 100000, N=0) at 0x100; executor returns ready 3 cycles after the strobe, JMP 0 -> one EXEC_FL_ pulse, CMD_ARG_ = 0, next header fetched at 0x104.
- Header 0x83000000 (N=3) at 0x0 with args 0x00200189, 0x00000FFF, 0x00000FFF -> CMD_ARG_ = 96'h00000FFF_00000FFF_00200189, CMD_FL_ = 6'b100000, next PC = 0x10.
- Jump: header at 0x40, ready with JMP_FL_ = 1 and offset 0xFFFFFFF0 -> next MEM_ADDR_ = 0x30. Offset 0x7 from 0xFFFFFFFC -> wraps to 0x0.
- Header flags 6'b000011 -> ERR_FL_ = 1, no EXEC_FL_ pulse. A later START_ to 0x200 -> fetch at 0x200.
- Header 0x00000000 -> HALTED_ = 1 and MEM_REQ_ = 0. Memory stalled 5 cycles on an argument fetch -> MEM_ADDR_ held stable throughout.
- Assert RST_ while in WAIT -> all outputs reach reset values asynchronously. A READY_FL_ arriving after reset is ignored.
